// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM access scheduler.
// Holds the scheduler state enum, cooldown default and QPI opcodes.
package psram_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      BUSY,
      COOLDOWN
   } psram_sched_state_e;

   localparam int SPI_RW_COOLDOWN_DEF = 10;

   localparam logic [7:0] QPI_CMD_ENTER = 8'h35;
   localparam logic [7:0] QPI_CMD_EXIT  = 8'hF5;
   localparam logic [7:0] QPI_CMD_READ  = 8'hEB;
   localparam logic [7:0] QPI_CMD_WRITE = 8'h38;

endpackage

// File: rtl/psram_access_scheduler_if.sv
// Requester and engine-side signals of the PSRAM access scheduler.
// master = requesters/engine environment, slave = scheduler.
interface psram_access_scheduler_if #(
   parameter int NUM_REQ             = 4,
   parameter int PSRAM_ADDRESS_WIDTH = 22
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]                     req_valid;
   logic [NUM_REQ-1:0]                     req_write;
   logic [NUM_REQ*PSRAM_ADDRESS_WIDTH-1:0] req_addr;
   logic [NUM_REQ-1:0]                     req_ready;
   logic [NUM_REQ-1:0]                     req_done;
   logic                                   eng_cmd_valid;
   logic                                   eng_cmd_write;
   logic [PSRAM_ADDRESS_WIDTH-1:0]         eng_cmd_addr;
   logic [IDW-1:0]                         eng_cmd_id;
   logic                                   eng_cmd_ready;
   logic                                   eng_done;

   modport master (
      output req_valid, req_write, req_addr,
      output eng_cmd_ready, eng_done,
      input  req_ready, req_done,
      input  eng_cmd_valid, eng_cmd_write,
      input  eng_cmd_addr, eng_cmd_id
   );

   modport slave (
      input  req_valid, req_write, req_addr,
      input  eng_cmd_ready, eng_done,
      output req_ready, req_done,
      output eng_cmd_valid, eng_cmd_write,
      output eng_cmd_addr, eng_cmd_id
   );

endinterface

// File: rtl/psram_access_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps.
// Produces a one-hot grant and the winner index.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   logic [IW:0] pos;
   logic        found;

   // first requester at or after ptr, modulo N
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         pos = {1'b0, ptr} + (IW+1)'(k);
         if (pos >= (IW+1)'(N))
            pos = pos - (IW+1)'(N);
         if (!found && req[pos[IW-1:0]]) begin
            found               = 1'b1;
            grant[pos[IW-1:0]]  = 1'b1;
            idx                 = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/psram_access_scheduler.sv
// Grants one block request at a time to the PSRAM engine, then cools down.
// Optional read-priority with write anti-starvation: PSRAM_SCHED_READ_PRIORITY_EN.
module psram_access_scheduler #(
   parameter int NUM_REQ             = 4,
   parameter int PSRAM_ADDRESS_WIDTH = 22,
   parameter int SPI_RW_COOLDOWN     = psram_pkg::SPI_RW_COOLDOWN_DEF,
   parameter int MAX_READ_STREAK     = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   psram_access_scheduler_if.slave bus,
   output logic                   busy
);
   import psram_pkg::*;

   localparam int AW  = PSRAM_ADDRESS_WIDTH;
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW  = (SPI_RW_COOLDOWN > 1) ? $clog2(SPI_RW_COOLDOWN) : 1;

   psram_sched_state_e state, state_nxt;

   logic [CW-1:0]      cnt, cnt_nxt;
   logic [IDW-1:0]     rr_ptr;
   logic [NUM_REQ-1:0] win_grant;
   logic [IDW-1:0]     win_idx;
   logic [AW-1:0]      win_addr;
   logic               win_write;
   logic               grant_en;
   logic               grant_fire;
   logic               lat_write;
   logic [AW-1:0]      lat_addr;
   logic [IDW-1:0]     lat_id;
   logic [NUM_REQ-1:0] done_q, done_nxt;

   // done_q is only non-zero in IDLE when the cooldown is zero
   assign grant_en   = resetn && (state == IDLE) && (done_q == '0);
   assign grant_fire = grant_en && (|bus.req_valid);

`ifdef PSRAM_SCHED_READ_PRIORITY_EN
   localparam int SW = (MAX_READ_STREAK > 0) ? $clog2(MAX_READ_STREAK + 1) : 1;

   logic [NUM_REQ-1:0] rd_req, wr_req, rd_gnt, wr_gnt;
   logic [IDW-1:0]     rd_idx, wr_idx;
   logic [SW-1:0]      streak;
   logic               pick_wr;

   assign rd_req = bus.req_valid & ~bus.req_write;
   assign wr_req = bus.req_valid & bus.req_write;

   rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_rd_arb (
      .req   (rd_req),
      .ptr   (rr_ptr),
      .grant (rd_gnt),
      .idx   (rd_idx)
   );

   rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_wr_arb (
      .req   (wr_req),
      .ptr   (rr_ptr),
      .grant (wr_gnt),
      .idx   (wr_idx)
   );

   assign pick_wr   = (|wr_req) &&
                      (!(|rd_req) || (streak == SW'(MAX_READ_STREAK)));
   assign win_grant = pick_wr ? wr_gnt : rd_gnt;
   assign win_idx   = pick_wr ? wr_idx : rd_idx;

   // count read grants that bypassed a waiting write
   always_ff @(posedge clk) begin
      if (!resetn)
         streak <= '0;
      else if (!(|wr_req))
         streak <= '0;
      else if (grant_fire)
         streak <= pick_wr ? '0 : streak + 1'b1;
   end
`else
   rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_arb (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (win_grant),
      .idx   (win_idx)
   );
`endif

   // fetch direction and address of the winning requester
   always_comb begin
      win_addr  = '0;
      win_write = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IDW'(i)) begin
            win_addr  = bus.req_addr[i*AW +: AW];
            win_write = bus.req_write[i];
         end
      end
   end

   // next state, cooldown count and completion pulse
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = '0;
      unique case (state)
         IDLE: begin
            if (grant_fire)
               state_nxt = ISSUE;
         end
         ISSUE: begin
            if (bus.eng_cmd_ready)
               state_nxt = BUSY;
         end
         BUSY: begin
            if (bus.eng_done) begin
               done_nxt[lat_id] = 1'b1;
               cnt_nxt          = '0;
               state_nxt        = (SPI_RW_COOLDOWN == 0) ? IDLE : COOLDOWN;
            end
         end
         COOLDOWN: begin
            if (cnt == CW'(SPI_RW_COOLDOWN - 1))
               state_nxt = IDLE;
            else
               cnt_nxt = cnt + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state, latched command and round-robin pointer
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         cnt       <= '0;
         rr_ptr    <= '0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_id    <= '0;
         done_q    <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         done_q <= done_nxt;
         if (grant_fire) begin
            lat_write <= win_write;
            lat_addr  <= win_addr;
            lat_id    <= win_idx;
            rr_ptr    <= (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
         end
      end
   end

   assign bus.req_ready     = grant_en ? win_grant : '0;
   assign bus.req_done      = done_q;
   assign bus.eng_cmd_valid = (state == ISSUE);
   assign bus.eng_cmd_write = lat_write;
   assign bus.eng_cmd_addr  = lat_addr;
   assign bus.eng_cmd_id    = lat_id;
   assign busy              = (state != IDLE);

endmodule
